// File: rtl/stdp_pkg.sv
// ---------------------------------------------------------------------------
// stdp_pkg
// Shared types and helpers for the STDP learner.
//   upd_kind_e      : kind of the last weight update (LTD / LTP)
//   stdp_delta      : update magnitude that halves every 2**tau_log2 cycles
//   stdp_sat_add    : add clamped at an upper bound
//   stdp_sat_sub    : subtract clamped at a lower bound
//   stdp_params_ok  : legality check for the parameter set of stdp_array
// ---------------------------------------------------------------------------
package stdp_pkg;

  typedef enum logic {
    UPD_LTD = 1'b0,
    UPD_LTP = 1'b1
  } upd_kind_e;

  // Amplitude decayed by one right shift per 2**tau_log2 cycles of distance.
  function automatic int unsigned stdp_delta(input int unsigned amp,
                                             input int unsigned dt,
                                             input int unsigned tau_log2);
    int unsigned shamt;
    shamt = dt >> tau_log2;
    // Very long distances are fully decayed; avoids relying on oversized shifts.
    if (shamt > 31) return 0;
    return amp >> shamt;
  endfunction

  // Weights and deltas both fit in W_WIDTH bits, so the sum never exceeds
  // W_WIDTH+1 bits before the clamp.
  function automatic int unsigned stdp_sat_add(input int unsigned w,
                                               input int unsigned delta,
                                               input int unsigned w_max);
    int unsigned sum;
    sum = w + delta;
    return (sum > w_max) ? w_max : sum;
  endfunction

  // Compare before subtracting so the unsigned result can never wrap.
  function automatic int unsigned stdp_sat_sub(input int unsigned w,
                                               input int unsigned delta,
                                               input int unsigned w_min);
    return (w < w_min + delta) ? w_min : w - delta;
  endfunction

  function automatic bit stdp_params_ok(input int n_pre,
                                        input int w_width,
                                        input int t_width,
                                        input int window,
                                        input int tau_log2,
                                        input int a_plus,
                                        input int a_minus,
                                        input int w_init,
                                        input int w_min,
                                        input int w_max);
    bit ok;
    ok = 1'b1;
    if (n_pre < 1) ok = 1'b0;
    if (w_width < 1 || w_width > 30) ok = 1'b0;
    if (t_width < 2 || t_width > 30) ok = 1'b0;
    if (tau_log2 < 0) ok = 1'b0;
    if (ok) begin
      // The timer must be able to exceed the window without saturating inside it.
      if (window < 0 || window >= (1 << t_width) - 1) ok = 1'b0;
      if (w_min < 0 || w_min > w_max || w_max > (1 << w_width) - 1) ok = 1'b0;
      if (w_init < w_min || w_init > w_max) ok = 1'b0;
      if (a_plus < 0 || a_plus > (1 << w_width) - 1) ok = 1'b0;
      if (a_minus < 0 || a_minus > (1 << w_width) - 1) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/stdp_array_if.sv
// ---------------------------------------------------------------------------
// stdp_array_if
// Spike inputs and weight/update outputs of the STDP learner.
//   pre_spike  : one bit per pre-synaptic channel
//   post_spike : post-synaptic spike
//   learn_en   : enables weight updates
//   weight     : flattened weights, channel i at [i*W_WIDTH +: W_WIDTH]
//   upd_valid  : one-cycle pulse per channel that updated
//   upd_ltp    : 1 = LTP, 0 = LTD, qualified by upd_valid
// master drives spikes (spike sources), slave is the learner.
// ---------------------------------------------------------------------------
interface stdp_array_if #(
  parameter int N_PRE   = 4,
  parameter int W_WIDTH = 8
);
  logic [N_PRE-1:0]         pre_spike;
  logic                     post_spike;
  logic                     learn_en;
  logic [N_PRE*W_WIDTH-1:0] weight;
  logic [N_PRE-1:0]         upd_valid;
  logic [N_PRE-1:0]         upd_ltp;

  modport master (
    output pre_spike, post_spike, learn_en,
    input  weight, upd_valid, upd_ltp
  );

  modport slave (
    input  pre_spike, post_spike, learn_en,
    output weight, upd_valid, upd_ltp
  );
endinterface

// File: rtl/stdp_synapse.sv
// ---------------------------------------------------------------------------
// stdp_synapse
// One plastic synapse: pre-spike timer, its seen flag, the weight register
// and the LTP/LTD decision.
//   clk, rst_n      : clock, async active-low reset
//   pre_spike_i     : this channel's pre spike
//   post_spike_i    : post spike (broadcast)
//   learn_en_i      : weight update enable (broadcast)
//   post_in_win_i   : post spike seen and post timer within the window
//   post_t_i        : post timer value (LTD distance)
//   weight_o        : current weight
//   upd_valid_o     : one-cycle update pulse
//   upd_ltp_o       : 1 when that update was LTP
// ---------------------------------------------------------------------------
module stdp_synapse
  import stdp_pkg::*;
#(
  parameter int W_WIDTH  = 8,
  parameter int T_WIDTH  = 8,
  parameter int WINDOW   = 20,
  parameter int TAU_LOG2 = 2,
  parameter int A_PLUS   = 16,
  parameter int A_MINUS  = 8,
  parameter int W_INIT   = 64,
  parameter int W_MIN    = 0,
  parameter int W_MAX    = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pre_spike_i,
  input  logic               post_spike_i,
  input  logic               learn_en_i,
  input  logic               post_in_win_i,
  input  logic [T_WIDTH-1:0] post_t_i,
  output logic [W_WIDTH-1:0] weight_o,
  output logic               upd_valid_o,
  output logic               upd_ltp_o
);

  localparam logic [T_WIDTH-1:0] T_MAX = '1;

  logic [T_WIDTH-1:0] pre_t_q, pre_t_d;
  logic               pre_seen_q, pre_seen_d;
  logic [W_WIDTH-1:0] weight_q, weight_d;
  logic               upd_valid_q, upd_valid_d;
  upd_kind_e          upd_kind_q, upd_kind_d;
  logic               ltp_fire, ltd_fire;

  always_comb begin
    pre_t_d     = pre_t_q;
    pre_seen_d  = pre_seen_q;
    weight_d    = weight_q;
    upd_valid_d = 1'b0;
    upd_kind_d  = UPD_LTD;

    // Timer restarts at 1 on a spike and otherwise counts up, sticking at max.
    if (pre_spike_i) begin
      pre_t_d    = T_WIDTH'(1);
      pre_seen_d = 1'b1;
    end else if (pre_t_q != T_MAX) begin
      pre_t_d = pre_t_q + T_WIDTH'(1);
    end

    // A coincident pre/post pair on this channel is neither LTP nor LTD.
    ltp_fire = post_spike_i && !pre_spike_i && pre_seen_q &&
               (pre_t_q <= T_WIDTH'(WINDOW));
    ltd_fire = pre_spike_i && !post_spike_i && post_in_win_i;

    if (learn_en_i) begin
      if (ltp_fire) begin
        weight_d    = W_WIDTH'(stdp_sat_add(32'(weight_q),
                        stdp_delta(A_PLUS, 32'(pre_t_q), TAU_LOG2), W_MAX));
        upd_valid_d = 1'b1;
        upd_kind_d  = UPD_LTP;
      end else if (ltd_fire) begin
        weight_d    = W_WIDTH'(stdp_sat_sub(32'(weight_q),
                        stdp_delta(A_MINUS, 32'(post_t_i), TAU_LOG2), W_MIN));
        upd_valid_d = 1'b1;
        upd_kind_d  = UPD_LTD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_t_q     <= '0;
      pre_seen_q  <= 1'b0;
      weight_q    <= W_WIDTH'(W_INIT);
      upd_valid_q <= 1'b0;
      upd_kind_q  <= UPD_LTD;
    end else begin
      pre_t_q     <= pre_t_d;
      pre_seen_q  <= pre_seen_d;
      weight_q    <= weight_d;
      upd_valid_q <= upd_valid_d;
      upd_kind_q  <= upd_kind_d;
    end
  end

  assign weight_o    = weight_q;
  assign upd_valid_o = upd_valid_q;
  assign upd_ltp_o   = (upd_kind_q == UPD_LTP);

endmodule

// File: rtl/stdp_array.sv
// ---------------------------------------------------------------------------
// stdp_array
// Pair-based STDP learner for one post-synaptic neuron and N_PRE synapses.
// Owns the post-spike timer and broadcasts it to one stdp_synapse per channel.
//   clk     : clock
//   rst_n   : async active-low reset
//   bus_io  : stdp_array_if slave (spikes and learn_en in; weights and update
//             pulses out). The interface instance must use the same N_PRE and
//             W_WIDTH as this module.
// ---------------------------------------------------------------------------
module stdp_array
  import stdp_pkg::*;
#(
  parameter int N_PRE    = 4,
  parameter int W_WIDTH  = 8,
  parameter int T_WIDTH  = 8,
  parameter int WINDOW   = 20,
  parameter int TAU_LOG2 = 2,
  parameter int A_PLUS   = 16,
  parameter int A_MINUS  = 8,
  parameter int W_INIT   = 64,
  parameter int W_MIN    = 0,
  parameter int W_MAX    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  stdp_array_if.slave bus_io
);

  localparam logic [T_WIDTH-1:0] T_MAX = '1;

  if (!stdp_params_ok(N_PRE, W_WIDTH, T_WIDTH, WINDOW, TAU_LOG2, A_PLUS,
                      A_MINUS, W_INIT, W_MIN, W_MAX)) begin : g_param_error
    $error("stdp_array: illegal parameter set");
  end

  logic [T_WIDTH-1:0]              post_t_q, post_t_d;
  logic                            post_seen_q, post_seen_d;
  logic                            post_in_win;
  logic [N_PRE-1:0][W_WIDTH-1:0]   weight_w;
  logic [N_PRE-1:0]                upd_valid_w;
  logic [N_PRE-1:0]                upd_ltp_w;

  // Post timer behaves exactly like the per-channel pre timers.
  always_comb begin
    post_t_d    = post_t_q;
    post_seen_d = post_seen_q;
    if (bus_io.post_spike) begin
      post_t_d    = T_WIDTH'(1);
      post_seen_d = 1'b1;
    end else if (post_t_q != T_MAX) begin
      post_t_d = post_t_q + T_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_t_q    <= '0;
      post_seen_q <= 1'b0;
    end else begin
      post_t_q    <= post_t_d;
      post_seen_q <= post_seen_d;
    end
  end

  assign post_in_win = post_seen_q && (post_t_q <= T_WIDTH'(WINDOW));

  for (genvar i = 0; i < N_PRE; i++) begin : g_syn
    stdp_synapse #(
      .W_WIDTH (W_WIDTH),
      .T_WIDTH (T_WIDTH),
      .WINDOW  (WINDOW),
      .TAU_LOG2(TAU_LOG2),
      .A_PLUS  (A_PLUS),
      .A_MINUS (A_MINUS),
      .W_INIT  (W_INIT),
      .W_MIN   (W_MIN),
      .W_MAX   (W_MAX)
    ) u_syn (
      .clk          (clk),
      .rst_n        (rst_n),
      .pre_spike_i  (bus_io.pre_spike[i]),
      .post_spike_i (bus_io.post_spike),
      .learn_en_i   (bus_io.learn_en),
      .post_in_win_i(post_in_win),
      .post_t_i     (post_t_q),
      .weight_o     (weight_w[i]),
      .upd_valid_o  (upd_valid_w[i]),
      .upd_ltp_o    (upd_ltp_w[i])
    );
  end

  assign bus_io.weight    = weight_w;
  assign bus_io.upd_valid = upd_valid_w;
  assign bus_io.upd_ltp   = upd_ltp_w;

endmodule

// File: tb/tb_stdp_array.sv
// ---------------------------------------------------------------------------
// tb_stdp_array
// Self-checking bench for stdp_array at default parameters. Vectors carry
// their expected outputs; each applied vector is pushed to a scoreboard and
// popped when the registered result appears one clock later.
// ---------------------------------------------------------------------------
module tb_stdp_array;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  stdp_array_if #(.N_PRE(4), .W_WIDTH(8)) bus ();

  stdp_array dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  typedef struct {
    logic [3:0]  pre;
    logic        post;
    logic        learn;
    logic [31:0] expW;
    logic [3:0]  expV;
    logic [3:0]  expL;
  } vec_t;

  localparam logic [31:0] W64 = {4{8'd64}};

  vec_t        vecs[$];
  vec_t        sb[$];
  logic [31:0] curW;
  int          nChecks = 0;
  int          nFails  = 0;
  int          scn     = 0;
  int          stepNo  = 0;

  function automatic logic [31:0] packW(input logic [7:0] w0, input logic [7:0] w1,
                                        input logic [7:0] w2, input logic [7:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic checkVal(input string what, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL s%0d.%0d %s: got %h expected %h", scn, stepNo, what, act, exp);
    end
  endtask

  task automatic addVec(input logic [3:0] pre, input logic post, input logic learn,
                        input logic [31:0] w, input logic [3:0] v, input logic [3:0] l);
    vec_t e;
    e.pre = pre; e.post = post; e.learn = learn;
    e.expW = w; e.expV = v; e.expL = l;
    vecs.push_back(e);
    curW = w;
  endtask

  task automatic addIdle(input int n, input logic learn);
    for (int i = 0; i < n; i++) addVec(4'b0000, 1'b0, learn, curW, 4'b0000, 4'b0000);
  endtask

  // Compares the oldest scoreboard entry against the registered outputs.
  task automatic checkOutput();
    vec_t e;
    if (sb.size() == 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL s%0d.%0d scoreboard: got empty queue expected an entry", scn, stepNo);
      return;
    end
    e = sb.pop_front();
    checkVal("weight", bus.weight, e.expW);
    checkVal("upd_valid", {28'd0, bus.upd_valid}, {28'd0, e.expV});
    checkVal("upd_ltp", {28'd0, bus.upd_ltp & e.expV}, {28'd0, e.expL & e.expV});
  endtask

  // Called at a negedge; drives one vector and checks it after the next posedge.
  task automatic applyStimulus(input vec_t v);
    bus.pre_spike  = v.pre;
    bus.post_spike = v.post;
    bus.learn_en   = v.learn;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic runTable();
    for (int i = 0; i < vecs.size(); i++) begin
      stepNo = i;
      applyStimulus(vecs[i]);
    end
    vecs.delete();
    bus.pre_spike  = 4'b0000;
    bus.post_spike = 1'b0;
    bus.learn_en   = 1'b1;
  endtask

  task automatic doReset();
    bus.pre_spike  = 4'b0000;
    bus.post_spike = 1'b0;
    bus.learn_en   = 1'b1;
    rst_n = 1'b0;
    #2;
    stepNo = -1;
    checkVal("reset_weight", bus.weight, W64);
    checkVal("reset_upd_valid", {28'd0, bus.upd_valid}, 32'd0);
    checkVal("reset_upd_ltp", {28'd0, bus.upd_ltp}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    curW = W64;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ltdDt[11] = '{1, 1, 1, 1, 1, 1, 1, 4, 12, 1, 1};
    int ltdW[11]  = '{56, 48, 40, 32, 24, 16, 8, 4, 3, 0, 0};
    logic [7:0] w0;

    rst_n = 1'b1;
    bus.pre_spike  = 4'b0000;
    bus.post_spike = 1'b0;
    bus.learn_en   = 1'b1;
    @(negedge clk);

    // First post after reset has no pre partner.
    scn = 1;
    doReset();
    addVec(4'b0000, 1'b1, 1'b1, W64, 4'b0000, 4'b0000);
    addIdle(1, 1'b1);
    runTable();

    // pre0 then post at dt=3: full LTP amplitude.
    scn = 2;
    doReset();
    addVec(4'b0001, 1'b0, 1'b1, W64, 4'b0000, 4'b0000);
    addIdle(2, 1'b1);
    addVec(4'b0000, 1'b1, 1'b1, packW(8'd80, 8'd64, 8'd64, 8'd64), 4'b0001, 4'b0001);
    addIdle(1, 1'b1);
    runTable();

    // post then pre1 at dt=9 (LTD 2), pre3 at dt=20 (delta 0), dt=21 and 30 (none).
    scn = 3;
    doReset();
    addVec(4'b0000, 1'b1, 1'b1, W64, 4'b0000, 4'b0000);
    addIdle(8, 1'b1);
    addVec(4'b0010, 1'b0, 1'b1, packW(8'd64, 8'd62, 8'd64, 8'd64), 4'b0010, 4'b0000);
    addIdle(10, 1'b1);
    addVec(4'b1000, 1'b0, 1'b1, curW, 4'b1000, 4'b0000);
    addVec(4'b1000, 1'b0, 1'b1, curW, 4'b0000, 4'b0000);
    addIdle(8, 1'b1);
    addVec(4'b0100, 1'b0, 1'b1, curW, 4'b0000, 4'b0000);
    addIdle(1, 1'b1);
    runTable();

    // Repeated dt=1 pairs saturate w0 at 255; pairs spaced so no LTD interferes.
    scn = 4;
    doReset();
    for (int k = 1; k <= 15; k++) begin
      w0 = (64 + 16 * k > 255) ? 8'd255 : 8'(64 + 16 * k);
      addVec(4'b0001, 1'b0, 1'b1, curW, 4'b0000, 4'b0000);
      addVec(4'b0000, 1'b1, 1'b1, packW(w0, 8'd64, 8'd64, 8'd64), 4'b0001, 4'b0001);
      addIdle(20, 1'b1);
    end
    runTable();

    // LTD walk of w0 down to 3, then delta 8 floors it at 0.
    scn = 5;
    doReset();
    for (int j = 0; j < 11; j++) begin
      addVec(4'b0000, 1'b1, 1'b1, curW, 4'b0000, 4'b0000);
      addIdle(ltdDt[j] - 1, 1'b1);
      addVec(4'b0001, 1'b0, 1'b1, packW(8'(ltdW[j]), 8'd64, 8'd64, 8'd64), 4'b0001, 4'b0000);
      addIdle(21, 1'b1);
    end
    runTable();

    // Coincident pre3/post blocks ch3 but not ch0; both timers restart.
    scn = 6;
    doReset();
    addIdle(1, 1'b1);
    addVec(4'b1000, 1'b0, 1'b1, W64, 4'b0000, 4'b0000);
    addVec(4'b0001, 1'b0, 1'b1, W64, 4'b0000, 4'b0000);
    addIdle(2, 1'b1);
    addVec(4'b1000, 1'b1, 1'b1, packW(8'd80, 8'd64, 8'd64, 8'd64), 4'b0001, 4'b0001);
    addIdle(1, 1'b1);
    addVec(4'b0000, 1'b1, 1'b1, packW(8'd88, 8'd64, 8'd64, 8'd80), 4'b1001, 4'b1001);
    addVec(4'b0100, 1'b0, 1'b1, packW(8'd88, 8'd64, 8'd56, 8'd80), 4'b0100, 4'b0000);
    runTable();

    // Reset asserted mid-cycle clears weights and the pending pulse at once.
    scn = 7;
    stepNo = -2;
    #3;
    rst_n = 1'b0;
    #1;
    checkVal("midreset_weight", bus.weight, W64);
    checkVal("midreset_upd_valid", {28'd0, bus.upd_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    curW = W64;
    // Pre flags cleared: post alone updates nothing; then pre0 sees the new post.
    addVec(4'b0000, 1'b1, 1'b1, W64, 4'b0000, 4'b0000);
    addVec(4'b0001, 1'b0, 1'b1, packW(8'd56, 8'd64, 8'd64, 8'd64), 4'b0001, 4'b0000);
    addIdle(1, 1'b1);
    runTable();

    // learn_en low blocks a dt=2 pair; re-enabled, the next dt=2 pair applies.
    scn = 8;
    doReset();
    addVec(4'b0001, 1'b0, 1'b0, W64, 4'b0000, 4'b0000);
    addIdle(1, 1'b0);
    addVec(4'b0000, 1'b1, 1'b0, W64, 4'b0000, 4'b0000);
    addIdle(20, 1'b1);
    addVec(4'b0001, 1'b0, 1'b1, W64, 4'b0000, 4'b0000);
    addIdle(1, 1'b1);
    addVec(4'b0000, 1'b1, 1'b1, packW(8'd80, 8'd64, 8'd64, 8'd64), 4'b0001, 4'b0001);
    addIdle(1, 1'b1);
    runTable();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
